uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel (tx_data / send / tx_data_ready) between NUM_REQ on-chip requesters.
- Uses round-robin arbitration with packet locking: once a requester wins, it keeps the channel until it sends a byte flagged last.
- Sequences the UART handshake per byte: issue send, confirm the UART accepted it, wait for transmit done.
- Sits between the fabric-side producers and the UART top's internal TX interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; matches the UART data type.
- START_TIMEOUT, 4, max cycles to wait for tx_data_ready to drop after send.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i at bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is the final one of a packet.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- tx_data  out  DATA_W  byte to the UART.
- send  out  1  one-cycle send strobe to the UART.
- tx_data_ready  in  1  UART idle / able to accept.
- grant_id  out  $clog2(NUM_REQ)  current or last owner.
- locked  out  1  a packet is in progress.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  one-cycle pulse on start timeout.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0; FSM = IDLE; rr_ptr = 0; lock cleared; timeout counter = 0.
  - Reset mid-transfer aborts immediately; no send is reissued.
- FSM states: IDLE, WAIT_START, WAIT_DONE.
- IDLE, entered with tx_data_ready=1:
  - Candidates: if locked, only the grant_id requester; otherwise all requesters with req_valid.
  - Unlocked winner = first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - In the winning cycle, all registered:
    - send=1 and tx_data=req_data[winner].
    - req_ready[winner]=1; the valid&ready handshake consumes the byte.
    - grant_id=winner.
    - locked = ~req_last[winner].
    - rr_ptr = winner+1 mod NUM_REQ, but only when req_last=1.
    - Go to WAIT_START.
- IDLE, no send issued when:
  - tx_data_ready=0, or no eligible valid requester.
  - If locked and the owner has no valid byte, stay in IDLE holding the lock; other requesters are starved by design.
- WAIT_START:
  - send=0; tx_data holds its value.
  - Count cycles; tx_data_ready=0 -> WAIT_DONE.
  - If the count reaches START_TIMEOUT with ready still 1:
    - Pulse timeout_err.
    - Clear the lock; advance rr_ptr past the owner.
    - Return to IDLE; the byte is lost and is not retried.
- WAIT_DONE: tx_data_ready=1 -> IDLE. No timeout, since the frame length depends on baud.
- send spacing: minimum 3 cycles between send pulses.
- Latency: valid with an idle UART and a won arbitration -> send/req_ready on the next clock edge.
- req_ready and send are never high in the same cycle as a state other than the IDLE->WAIT_START transition.
- Requester rules:
  - A requester must hold valid/data/last stable until ready.
  - Dropping valid before ready is legal; the arbiter simply does not grant it.
- busy = (state != IDLE).
- Edge cases:
  - NUM_REQ not a power of 2: wrap via explicit compare, not bit truncation.
  - Simultaneous requests from all requesters with last=1 are served 0,1,2,3,0,... from reset.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- When defined:
  - Requester 0 is high priority. When not locked and req_valid[0]=1, requester 0 wins regardless of rr_ptr.
  - rr_ptr is not updated by requester 0 grants.
  - Locks held by other requesters are still honoured.
- When undefined: pure round-robin as above.

Test Plan:
- Setup for all scenarios: UART model drops tx_data_ready 1 cycle after send and holds it low 20 cycles.
- Round-robin fairness:
  - Stimulus: all 4 valid, last=1, data 0xA0+i.
  - Response: send order 0xA0,0xA1,0xA2,0xA3,0xA0; each req_ready a single cycle; send spacing >= 22 cycles.
- Packet lock:
  - Stimulus: req1 sends 3 bytes 0x11,0x22,0x33 with last only on 0x33; req0 and req2 valid throughout.
  - Response: 0x11,0x22,0x33 sent consecutively; locked=1 until the 0x33 grant; next grant goes to req2.
- Start timeout:
  - Stimulus: UART model holds tx_data_ready=1 after send.
  - Response: timeout_err pulses 4 cycles after WAIT_START entry; FSM returns to IDLE; locked=0.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 while in WAIT_DONE.
  - Response: outputs 0 asynchronously; after release, first grant goes to req0 (rr_ptr=0).
- Idle lock hold:
  - Stimulus: req3 sends a byte with last=0, then drops valid for 50 cycles while req0 is valid.
  - Response: no send for 50 cycles; locked=1; grant_id=3.
- Priority (macro defined):
  - Stimulus: rr_ptr=2; req0 and req2 valid.
  - Response: req0 is granted first, then req2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of a single UART transmit channel.
// Define UART_TX_ARB_PRIO0_EN to give requester 0 absolute priority whenever no lock is held.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       send,
  input  logic                       tx_data_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       busy,
  output logic                       timeout_err
);

  // state      | meaning
  // IDLE       | arbitrate; issue send when the UART is idle and a requester is eligible
  // WAIT_START | send issued; wait for tx_data_ready to drop, bounded by START_TIMEOUT
  // WAIT_DONE  | UART transmitting; wait for tx_data_ready to return
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [ID_W:0]      NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(START_TIMEOUT - 1);
`ifdef UART_TX_ARB_PRIO0_EN
  localparam bit PRIO0_EN = 1'b1;
`else
  localparam bit PRIO0_EN = 1'b0;
`endif

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_n, grant_id_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                locked_n, send_n, timeout_err_n;
  logic [NUM_REQ-1:0]  req_ready_n;
  logic [DATA_W-1:0]   tx_data_n;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W:0]       cand;

  // Wrap by compare so non-power-of-two NUM_REQ works.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if ({1'b0, id} == NUM_REQ_W - 1'b1) return '0;
    else return id + 1'b1;
  endfunction

  // Descending scan so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id;
    cand       = '0;
    if (locked) begin
      pick_found = req_valid[grant_id];
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        cand = {1'b0, rr_ptr} + (ID_W + 1)'(i);
        if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
        if (req_valid[cand[ID_W-1:0]]) begin
          pick_found = 1'b1;
          pick_id    = cand[ID_W-1:0];
        end
      end
      if (PRIO0_EN && req_valid[0]) begin
        pick_found = 1'b1;
        pick_id    = '0;
      end
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    cnt_n         = cnt;
    locked_n      = locked;
    grant_id_n    = grant_id;
    tx_data_n     = tx_data;
    send_n        = 1'b0;
    req_ready_n   = '0;
    timeout_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (tx_data_ready && pick_found) begin
          send_n               = 1'b1;
          tx_data_n            = req_data[int'(pick_id)*DATA_W +: DATA_W];
          req_ready_n[pick_id] = 1'b1;
          grant_id_n           = pick_id;
          locked_n             = ~req_last[pick_id];
          if (req_last[pick_id] && !(PRIO0_EN && pick_id == '0))
            rr_ptr_n = next_id(pick_id);
          cnt_n                = CNT_LOAD;
          state_n              = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!tx_data_ready) begin
          cnt_n   = '0;
          state_n = WAIT_DONE;
        end else if (cnt == '0) begin
          // Byte is dropped; release the channel so one stuck packet cannot hog it.
          timeout_err_n = 1'b1;
          locked_n      = 1'b0;
          if (!(PRIO0_EN && grant_id == '0)) rr_ptr_n = next_id(grant_id);
          state_n       = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_data_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      locked      <= 1'b0;
      grant_id    <= '0;
      tx_data     <= '0;
      send        <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      cnt         <= cnt_n;
      locked      <= locked_n;
      grant_id    <= grant_id_n;
      tx_data     <= tx_data_n;
      send        <= send_n;
      req_ready   <= req_ready_n;
      timeout_err <= timeout_err_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven requesters, a UART model and
// an arbitration reference model kept as plain integers (pointer, owner, lock flag).
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0]   tx_data;
  logic           send, tx_data_ready, locked, busy, timeout_err;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .send(send),
    .tx_data_ready(tx_data_ready), .grant_id(grant_id), .locked(locked),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // UART: ready drops the cycle after send and stays low for 20 cycles.
  bit uart_stuck = 1'b0;
  int lo_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_ready <= 1'b1;
      lo_cnt        <= 0;
    end else if (send && !uart_stuck) begin
      tx_data_ready <= 1'b0;
      lo_cnt        <= 20;
    end else if (lo_cnt > 1) begin
      lo_cnt <= lo_cnt - 1;
    end else if (lo_cnt == 1) begin
      lo_cnt        <= 0;
      tx_data_ready <= 1'b1;
    end
  end

  logic [W-1:0] q_data[N][$];
  bit           q_last[N][$];
  bit [N-1:0]   en = '1, pop_pend = '0, prev_valid = '0;
  int  m_rr = 0, m_owner = 0, cyc = 0, rdy_cycles = 0;
  bit  m_lock = 0;
  int  obs_data[$], obs_gid[$], obs_ready[$], obs_lock[$], obs_cyc[$];
  int  exp_data[$], exp_gid[$], exp_lock[$], to_cyc[$];

`ifdef UART_TX_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  function automatic int model_pick(bit [N-1:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < N; k++) if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (q_data[i].size() > 0) begin
        req_valid[i]      = en[i] || pop_pend[i];
        req_data[i*W +: W] = q_data[i][0];
        req_last[i]       = q_last[i][0];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]       = 1'b0;
      end
    end
    prev_valid = req_valid;
  endtask

  task automatic tick();
    int w;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++)
      if (pop_pend[i] && q_data[i].size() > 0) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    pop_pend = '0;
    if (req_ready != '0) rdy_cycles++;
    if (send) begin
      w = model_pick(prev_valid);
      obs_data.push_back(int'(tx_data));
      obs_gid.push_back(int'(grant_id));
      obs_ready.push_back(int'(req_ready));
      obs_lock.push_back(int'(locked));
      obs_cyc.push_back(cyc);
      exp_gid.push_back(w);
      if (w >= 0) begin
        exp_data.push_back(int'(q_data[w][0]));
        exp_lock.push_back(q_last[w][0] ? 0 : 1);
        m_lock  = !q_last[w][0];
        m_owner = w;
        if (q_last[w][0] && !(PRIO && w == 0)) m_rr = (w + 1) % N;
        pop_pend[w] = 1'b1;
      end else begin
        exp_data.push_back(-1);
        exp_lock.push_back(-1);
      end
    end
    if (timeout_err) begin
      to_cyc.push_back(cyc);
      m_lock = 0;
      if (!(PRIO && m_owner == 0)) m_rr = (m_owner + 1) % N;
    end
    drive_inputs();
  endtask

  task automatic clear_logs();
    obs_data.delete(); obs_gid.delete(); obs_ready.delete(); obs_lock.delete();
    obs_cyc.delete(); exp_data.delete(); exp_gid.delete(); exp_lock.delete();
    to_cyc.delete(); rdy_cycles = 0;
  endtask

  task automatic push(input int r, input int d, input bit last);
    q_data[r].push_back(W'(d));
    q_last[r].push_back(last);
  endtask

  task automatic wait_sends(input int n, input int budget);
    int b = 0;
    while (obs_data.size() < n && b < budget) begin tick(); b++; end
    checks++;
    if (obs_data.size() < n) begin
      errors++;
      $display("FAIL wait_sends: observed %0d sends, required %0d", obs_data.size(), n);
    end
  endtask

  task automatic drain(input int budget);
    int b = 0;
    bit empty;
    do begin
      tick(); b++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (q_data[i].size() > 0) empty = 1'b0;
    end while (!(empty && !busy && pop_pend == '0) && b < budget);
    checks++;
    if (b >= budget) begin
      errors++;
      $display("FAIL drain: queues not emptied within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    checks += 7;
    if (send !== 1'b0)        begin errors++; $display("FAIL reset_send: got %b, want 0", send); end
    if (req_ready !== '0)     begin errors++; $display("FAIL reset_req_ready: got %b, want 0", req_ready); end
    if (tx_data !== '0)       begin errors++; $display("FAIL reset_tx_data: got %h, want 00", tx_data); end
    if (grant_id !== '0)      begin errors++; $display("FAIL reset_grant_id: got %0d, want 0", grant_id); end
    if (locked !== 1'b0)      begin errors++; $display("FAIL reset_locked: got %b, want 0", locked); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b, want 0", timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    clear_logs();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 'hA0 + i, 1'b1);
    wait_sends(5, 400);
    for (int k = 0; k < 5; k++) begin
      checks += 3;
      if (obs_data[k] !== 'hA0 + (k % N)) begin errors++; $display("FAIL rr_data[%0d]: got %h, want %h", k, obs_data[k], 'hA0 + (k % N)); end
      if (obs_gid[k] !== k % N) begin errors++; $display("FAIL rr_grant[%0d]: got %0d, want %0d", k, obs_gid[k], k % N); end
      if (obs_ready[k] !== (1 << (k % N))) begin errors++; $display("FAIL rr_ready[%0d]: got %b, want %b", k, obs_ready[k], 1 << (k % N)); end
      if (k > 0) begin
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] < 22) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles, want >=22", k, obs_cyc[k] - obs_cyc[k-1]); end
      end
    end
    drain(400);
    checks++;
    if (rdy_cycles !== obs_data.size()) begin errors++; $display("FAIL rr_ready_width: got %0d ready cycles, want %0d", rdy_cycles, obs_data.size()); end
  endtask

  task automatic test_packet_lock();
    clear_logs();
    push(1, 'h11, 1'b0); push(1, 'h22, 1'b0); push(1, 'h33, 1'b1);
    wait_sends(1, 50);
    push(0, 'h50, 1'b1); push(0, 'h51, 1'b1);
    push(2, 'h60, 1'b1); push(2, 'h61, 1'b1);
    wait_sends(4, 200);
    checks += 5;
    if (obs_data[0] !== 'h11 || obs_data[1] !== 'h22 || obs_data[2] !== 'h33)
      begin errors++; $display("FAIL lock_seq: got %h %h %h, want 11 22 33", obs_data[0], obs_data[1], obs_data[2]); end
    if (obs_lock[0] !== 1 || obs_lock[1] !== 1) begin errors++; $display("FAIL lock_held: got %0d %0d, want 1 1", obs_lock[0], obs_lock[1]); end
    if (obs_lock[2] !== 0) begin errors++; $display("FAIL lock_release: got %0d, want 0", obs_lock[2]); end
    if (obs_gid[3] !== 2) begin errors++; $display("FAIL lock_next_grant: got %0d, want 2", obs_gid[3]); end
    if (obs_data[3] !== 'h60) begin errors++; $display("FAIL lock_next_data: got %h, want 60", obs_data[3]); end
    drain(400);
    for (int k = 0; k < obs_data.size(); k++) begin
      checks += 2;
      if (obs_data[k] !== exp_data[k]) begin errors++; $display("FAIL lock_model_data[%0d]: got %h, want %h", k, obs_data[k], exp_data[k]); end
      if (obs_gid[k] !== exp_gid[k]) begin errors++; $display("FAIL lock_model_grant[%0d]: got %0d, want %0d", k, obs_gid[k], exp_gid[k]); end
    end
  endtask

  task automatic test_start_timeout();
    int r, b;
    clear_logs();
    r = int'($urandom_range(0, N - 1));
    uart_stuck = 1'b1;
    push(r, int'($urandom_range(0, 255)), 1'b0);
    wait_sends(1, 60);
    b = 0;
    while (to_cyc.size() == 0 && b < 20) begin tick(); b++; end
    checks += 2;
    if (to_cyc.size() == 0) begin errors++; $display("FAIL timeout_pulse: got none within 20 cycles, want one"); end
    else if (to_cyc[0] - obs_cyc[0] !== 4) begin errors++; $display("FAIL timeout_delay: got %0d cycles, want 4", to_cyc[0] - obs_cyc[0]); end
    if (obs_lock[0] !== 1) begin errors++; $display("FAIL timeout_lock_set: got %0d, want 1", obs_lock[0]); end
    tick();
    checks += 3;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b, want 0", timeout_err); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL timeout_idle: busy got %b, want 0", busy); end
    if (locked !== 1'b0)      begin errors++; $display("FAIL timeout_unlock: got %b, want 0", locked); end
    uart_stuck = 1'b0;
    push(r, 'h5A, 1'b1);
    push((r + 1) % N, 'hA5, 1'b1);
    wait_sends(3, 200);
    checks += 2;
    if (obs_gid[1] !== (r + 1) % N) begin errors++; $display("FAIL timeout_rr_next: got %0d, want %0d", obs_gid[1], (r + 1) % N); end
    if (obs_gid[2] !== r) begin errors++; $display("FAIL timeout_rr_after: got %0d, want %0d", obs_gid[2], r); end
    drain(300);
  endtask

  task automatic test_idle_lock();
    clear_logs();
    push(3, 'h3C, 1'b0);
    wait_sends(1, 50);
    push(0, 'h0A, 1'b1);
    repeat (73) tick();
    checks += 4;
    if (obs_data.size() !== 1) begin errors++; $display("FAIL idle_lock_sends: got %0d, want 1", obs_data.size()); end
    if (locked !== 1'b1)       begin errors++; $display("FAIL idle_lock_locked: got %b, want 1", locked); end
    if (grant_id !== 2'd3)     begin errors++; $display("FAIL idle_lock_grant: got %0d, want 3", grant_id); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL idle_lock_busy: got %b, want 0", busy); end
    push(3, 'h3D, 1'b1);
    wait_sends(3, 200);
    checks += 2;
    if (obs_gid[1] !== 3 || obs_data[1] !== 'h3D) begin errors++; $display("FAIL idle_lock_close: got req%0d %h, want req3 3d", obs_gid[1], obs_data[1]); end
    if (obs_gid[2] !== 0 || obs_data[2] !== 'h0A) begin errors++; $display("FAIL idle_lock_release: got req%0d %h, want req0 0a", obs_gid[2], obs_data[2]); end
    drain(200);
  endtask

  task automatic test_reset_midframe();
    int d[N];
    clear_logs();
    push(2, 'h2A, 1'b0);
    wait_sends(1, 50);
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || tx_data_ready !== 1'b0) begin errors++; $display("FAIL midframe_state: busy %b ready %b, want 1 0", busy, tx_data_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({send, req_ready, tx_data, grant_id, locked, busy, timeout_err} !== '0)
      begin errors++; $display("FAIL midframe_async_clear: got %b, want all 0", {send, req_ready, tx_data, grant_id, locked, busy, timeout_err}); end
    for (int i = 0; i < N; i++) begin q_data[i].delete(); q_last[i].delete(); end
    pop_pend = '0; m_rr = 0; m_lock = 0; m_owner = 0;
    clear_logs();
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin d[i] = int'($urandom_range(0, 255)); push(i, d[i], 1'b1); end
    wait_sends(4, 200);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_gid[k] !== k || obs_data[k] !== d[k]) begin errors++; $display("FAIL midframe_order[%0d]: got req%0d %h, want req%0d %h", k, obs_gid[k], obs_data[k], k, d[k]); end
    end
    drain(200);
  endtask

  task automatic test_random();
    int r, b;
    bit empty;
    clear_logs();
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, N - 1));
      push(r, int'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < N; i++) if (q_last[i].size() > 0) q_last[i][q_last[i].size() - 1] = 1'b1;
    b = 0;
    do begin
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
      tick(); b++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (q_data[i].size() > 0) empty = 1'b0;
    end while (!empty && b < 5000);
    en = '1;
    drain(200);
    checks += 3;
    if (obs_data.size() !== 60) begin errors++; $display("FAIL rand_count: got %0d sends, want 60", obs_data.size()); end
    if (to_cyc.size() !== 0) begin errors++; $display("FAIL rand_timeouts: got %0d, want 0", to_cyc.size()); end
    if (rdy_cycles !== obs_data.size()) begin errors++; $display("FAIL rand_ready_width: got %0d, want %0d", rdy_cycles, obs_data.size()); end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks += 4;
      if (obs_data[k] !== exp_data[k]) begin errors++; $display("FAIL rand_data[%0d]: got %h, want %h", k, obs_data[k], exp_data[k]); end
      if (obs_gid[k] !== exp_gid[k]) begin errors++; $display("FAIL rand_grant[%0d]: got %0d, want %0d", k, obs_gid[k], exp_gid[k]); end
      if (obs_lock[k] !== exp_lock[k]) begin errors++; $display("FAIL rand_lock[%0d]: got %0d, want %0d", k, obs_lock[k], exp_lock[k]); end
      if (exp_gid[k] < 0 || obs_ready[k] !== (1 << exp_gid[k])) begin errors++; $display("FAIL rand_ready[%0d]: got %b, want req%0d", k, obs_ready[k], exp_gid[k]); end
      if (k > 0) begin
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] < 3) begin errors++; $display("FAIL rand_spacing[%0d]: got %0d, want >=3", k, obs_cyc[k] - obs_cyc[k-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_start_timeout();
    test_idle_lock();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
